dac_spi_tx: RTL and testbench



---
 rtl/fgen_pkg.sv | 44 ++++
 rtl/spi_frame_shifter.sv | 83 ++++++++
 rtl/dac_spi_tx.sv | 139 +++++++++++++
 tb/tb_dac_spi_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fgen_pkg.sv
// Shared definitions for the function-generator DAC path: SPI frame layout,
// transmitter FSM encoding and the frame assembly helper.
package fgen_pkg;

  localparam int FRAME_W      = 16;
  localparam int DATA_FIELD_W = 12;

  // Frame bit positions (MCP4922-class command word)
  localparam int BIT_CH   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

  // Assemble {ch, BUF, GA_N, SHDN_N, data[11:0]}
  function automatic logic [FRAME_W-1:0] make_frame(
    input ch_e                     ch,
    input logic                    buf_bit,
    input logic                    ga_n_bit,
    input logic                    shdn_n,
    input logic [DATA_FIELD_W-1:0] data
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[BIT_CH]            = ch;
    f[BIT_BUF]           = buf_bit;
    f[BIT_GA]            = ga_n_bit;
    f[BIT_SHDN]          = shdn_n;
    f[DATA_FIELD_W-1:0]  = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// 16-bit SPI mode-0 shifter. A start pulse loads a frame; each bit is a low
// half then a high half of CLKDIV clk cycles. mosi moves only when sclk falls,
// and the register shifts in zeros so mosi is 0 once the frame is out.
module spi_frame_shifter
  import fgen_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] data,
  output logic               sclk,
  output logic               mosi,
  output logic               active,
  output logic               done
);

  localparam int            HW   = $clog2(CLKDIV + 1);
  localparam logic [HW-1:0] HMAX = HW'(CLKDIV - 1);

  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sclk_q, sclk_d;
  logic               active_q, active_d;
  logic               half_end;

  assign half_end = active_q && (hcnt_q == HMAX);
  // Last cycle of the 16th high half
  assign done     = half_end && sclk_q && (bit_q == 4'd15);
  assign sclk     = sclk_q;
  assign mosi     = shreg_q[FRAME_W-1];
  assign active   = active_q;

  // Half-period sequencing: load on start, toggle sclk every CLKDIV cycles
  always_comb begin
    hcnt_d   = hcnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    active_d = active_q;
    if (start && !active_q) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      shreg_d  = data;
      bit_d    = 4'd0;
      hcnt_d   = '0;
    end else if (active_q) begin
      if (half_end) begin
        hcnt_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd15) active_d = 1'b0;
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // State registers; pins must read idle immediately on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q   <= '0;
      bit_q    <= 4'd0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Dual-channel SPI transmitter for an MCP4922-class DAC. Snapshots a
// channel-1/channel-2 pair, sends frame A then frame B, then strobes ldac_n
// so both outputs update together.
module dac_spi_tx
  import fgen_pkg::*;
#(
  parameter int OW     = 12,
  parameter int CLKDIV = 2,
  parameter int CS_GAP = 2,
  parameter int LDAC_W = 2,
  parameter bit BUF    = 1'b0,
  parameter bit GA_N   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [OW-1:0] sample_ch1,
  input  logic [OW-1:0] sample_ch2,
  input  logic          ch1_en,
  input  logic          ch2_en,
  output logic          sclk,
  output logic          mosi,
  output logic          cs_n,
  output logic          ldac_n,
  output logic          busy,
  output logic          pair_done
);

  localparam int            CNT_MAX    = (CS_GAP > LDAC_W) ? CS_GAP : LDAC_W;
  localparam int            CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LDAC_W - 1);

  state_e             state_q, state_d;
  ch_e                ch_q, ch_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OW-1:0]      smp2_q;
  logic               shdn2_q;
  logic               cs_n_q, ldac_n_q, busy_q, pair_done_q;
  logic               snap, sh_start, sh_active, sh_done;
  logic [FRAME_W-1:0] sh_data;

  // Frame A is loaded straight from the inputs on the snapshot cycle, so the
  // shifter itself holds the channel-1 snapshot; only channel 2 is stored here.
  assign sh_data = (state_q == ST_IDLE)
                 ? make_frame(CH_A, BUF, GA_N, ch1_en, sample_ch1)
                 : make_frame(CH_B, BUF, GA_N, shdn2_q, smp2_q);

  spi_frame_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .data   (sh_data),
    .sclk   (sclk),
    .mosi   (mosi),
    .active (sh_active),
    .done   (sh_done)
  );

  // Pair sequencing: IDLE -> SHIFT(A) -> GAP -> SHIFT(B) -> GAP -> LATCH
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    snap     = 1'b0;
    sh_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !sh_active) begin
          snap     = 1'b1;
          sh_start = 1'b1;
          ch_d     = CH_A;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (ch_q == CH_A) begin
            ch_d     = CH_B;
            sh_start = 1'b1;
            state_d  = ST_SHIFT;
          end else begin
            state_d = ST_LATCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) state_d = ST_IDLE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and pin registers; pins are decoded from the next state so they line
  // up with the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= CH_A;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      pair_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= (state_d != ST_SHIFT);
      ldac_n_q    <= (state_d != ST_LATCH);
      busy_q      <= (state_d != ST_IDLE);
      pair_done_q <= (state_d == ST_LATCH) && (cnt_d == LATCH_LAST);
    end
  end

  // Channel-2 snapshot, held until the next pair starts
  always_ff @(posedge clk) begin
    if (snap) begin
      smp2_q  <= sample_ch2;
      shdn2_q <= ch2_en;
    end
  end

  assign cs_n      = cs_n_q;
  assign ldac_n    = ldac_n_q;
  assign busy      = busy_q;
  assign pair_done = pair_done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default instance and a fastest-timing instance,
// with a pin-level SPI decoder and an arithmetic frame/timing model.
module tb_dac_spi_tx;

  localparam logic TB_BUF  = 1'b0;
  localparam logic TB_GA_N = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_d, en_f, ch1_en, ch2_en;
  logic [11:0] s1, s2;
  logic d_sclk, d_mosi, d_cs_n, d_ldac_n, d_busy, d_pd;
  logic f_sclk, f_mosi, f_cs_n, f_ldac_n, f_busy, f_pd;

  dac_spi_tx dut (
    .clk(clk), .rst(rst), .en(en_d), .sample_ch1(s1), .sample_ch2(s2),
    .ch1_en(ch1_en), .ch2_en(ch2_en), .sclk(d_sclk), .mosi(d_mosi),
    .cs_n(d_cs_n), .ldac_n(d_ldac_n), .busy(d_busy), .pair_done(d_pd)
  );

  dac_spi_tx #(.CLKDIV(1), .CS_GAP(1), .LDAC_W(1)) dut_f (
    .clk(clk), .rst(rst), .en(en_f), .sample_ch1(s1), .sample_ch2(s2),
    .ch1_en(ch1_en), .ch2_en(ch2_en), .sclk(f_sclk), .mosi(f_mosi),
    .cs_n(f_cs_n), .ldac_n(f_ldac_n), .busy(f_busy), .pair_done(f_pd)
  );

  int   sel = 0;
  logic m_sclk, m_mosi, m_cs_n, m_ldac_n, m_busy, m_pd;
  assign m_sclk   = (sel != 0) ? f_sclk   : d_sclk;
  assign m_mosi   = (sel != 0) ? f_mosi   : d_mosi;
  assign m_cs_n   = (sel != 0) ? f_cs_n   : d_cs_n;
  assign m_ldac_n = (sel != 0) ? f_ldac_n : d_ldac_n;
  assign m_busy   = (sel != 0) ? f_busy   : d_busy;
  assign m_pd     = (sel != 0) ? f_pd     : d_pd;

  int checks = 0;
  int failures = 0;

  // Pin-level decoder state
  logic        p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_busy = 1'b0;
  logic [15:0] word = '0;
  int nbits = 0, cslow = 0, ldlow = 0, bhigh = 0, cyc = 0;
  int hi_toggle = 0, sclk_no_cs = 0, pd_cnt = 0;
  logic [15:0] fr_q[$];
  int nb_q[$], cs_q[$], ld_q[$], bh_q[$], br_q[$];

  // Decode SPI frames on the falling clk edge, away from DUT updates
  always @(negedge clk) begin
    cyc++;
    if (!m_cs_n) begin
      cslow++;
      if (m_sclk && !p_sclk) begin
        word = {word[14:0], m_mosi};
        nbits++;
      end
    end else if (m_sclk && !p_sclk) begin
      sclk_no_cs++;
    end
    if (m_sclk && p_sclk && (m_mosi !== p_mosi)) hi_toggle++;
    if (m_cs_n && !p_cs) begin
      fr_q.push_back(word); nb_q.push_back(nbits); cs_q.push_back(cslow);
      word = '0; nbits = 0; cslow = 0;
    end
    if (!m_ldac_n) ldlow++;
    if (m_ldac_n && !p_ldac) begin ld_q.push_back(ldlow); ldlow = 0; end
    if (m_busy) bhigh++;
    if (m_busy && !p_busy) br_q.push_back(cyc);
    if (!m_busy && p_busy) begin bh_q.push_back(bhigh); bhigh = 0; end
    if (m_pd) pd_cnt++;
    p_sclk = m_sclk; p_mosi = m_mosi; p_cs = m_cs_n; p_ldac = m_ldac_n; p_busy = m_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_frame(input int ch, input logic shdn, input logic [11:0] d);
    return 16'(ch * 32768 + int'(TB_BUF) * 16384 + int'(TB_GA_N) * 8192 + int'(shdn) * 4096 + int'(d));
  endfunction

  task automatic set_en(input logic v);
    if (sel != 0) en_f = v; else en_d = v;
  endtask

  task automatic flush;
    fr_q.delete(); nb_q.delete(); cs_q.delete(); ld_q.delete(); bh_q.delete(); br_q.delete();
    pd_cnt = 0; hi_toggle = 0; sclk_no_cs = 0;
  endtask

  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (scramble) begin
        s1 = 12'($urandom); s2 = 12'($urandom);
        ch1_en = 1'($urandom); ch2_en = 1'($urandom);
      end
      if (!m_busy) break;
      n++;
    end
    chk("idle_reached", 32'(n < 3000), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic one_pair(input logic [11:0] a, input logic [11:0] b, input logic ea,
                          input logic eb, input int hold);
    @(negedge clk);
    s1 = a; s2 = b; ch1_en = ea; ch2_en = eb;
    set_en(1'b1);
    repeat (hold) @(posedge clk);
    #1 set_en(1'b0);
    wait_idle(1'b1);
  endtask

  task automatic check_pair(input string nm, input logic [11:0] a, input logic [11:0] b,
                            input logic ea, input logic eb, input int h, input int g, input int l);
    logic [15:0] fa, fb;
    int per;
    per = 1 + 2 * (32 * h + g) + l;
    fa = 16'hxxxx; fb = 16'hxxxx;
    chk({nm, "_nframes"}, 32'(fr_q.size()), 32'd2);
    if (fr_q.size() > 0) fa = fr_q.pop_front();
    if (fr_q.size() > 0) fb = fr_q.pop_front();
    chk({nm, "_frameA"}, 32'(fa), 32'(exp_frame(0, ea, a)));
    chk({nm, "_frameB"}, 32'(fb), 32'(exp_frame(1, eb, b)));
    chk({nm, "_bitsA"}, (nb_q.size() > 0) ? 32'(nb_q[0]) : 32'hffff, 32'd16);
    chk({nm, "_csA"}, (cs_q.size() > 0) ? 32'(cs_q[0]) : 32'hffff, 32'(32 * h));
    chk({nm, "_csB"}, (cs_q.size() > 1) ? 32'(cs_q[1]) : 32'hffff, 32'(32 * h));
    chk({nm, "_nldac"}, 32'(ld_q.size()), 32'd1);
    chk({nm, "_ldac_w"}, (ld_q.size() > 0) ? 32'(ld_q[0]) : 32'hffff, 32'(l));
    chk({nm, "_period"}, (bh_q.size() > 0) ? 32'(bh_q[0] + 1) : 32'hffff, 32'(per));
    chk({nm, "_pair_done"}, 32'(pd_cnt), 32'd1);
    chk({nm, "_mosi_hi_stable"}, 32'(hi_toggle), 32'd0);
    chk({nm, "_sclk_outside_cs"}, 32'(sclk_no_cs), 32'd0);
    flush();
  endtask

  task automatic b2b(input string nm, input logic [11:0] a, input logic [11:0] b, input int per);
    int n;
    logic [15:0] fa, fb;
    flush();
    @(negedge clk);
    s1 = a; s2 = b; ch1_en = 1'b1; ch2_en = 1'b1;
    set_en(1'b1);
    n = 0;
    while (br_q.size() < 3 && n < 1000) begin @(posedge clk); #1; n++; end
    set_en(1'b0);
    chk({nm, "_started3"}, 32'(n < 1000), 32'd1);
    chk({nm, "_period1"}, (br_q.size() > 2) ? 32'(br_q[1] - br_q[0]) : 32'hffff, 32'(per));
    chk({nm, "_period2"}, (br_q.size() > 2) ? 32'(br_q[2] - br_q[1]) : 32'hffff, 32'(per));
    repeat (2 * per) @(posedge clk);
    #1;
    chk({nm, "_idle_busy"}, 32'(m_busy), 32'd0);
    fa = (fr_q.size() > 2) ? fr_q[2] : 16'hxxxx;
    fb = (fr_q.size() > 3) ? fr_q[3] : 16'hxxxx;
    chk({nm, "_frameA"}, 32'(fa), 32'(exp_frame(0, 1'b1, a)));
    chk({nm, "_frameB"}, 32'(fb), 32'(exp_frame(1, 1'b1, b)));
    flush();
  endtask

  initial begin
    logic [11:0] ra, rb;
    logic        rea, reb;
    int          n;
    rst = 1'b0; en_d = 1'b0; en_f = 1'b0;
    s1 = '0; s2 = '0; ch1_en = 1'b0; ch2_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(d_cs_n), 32'd1);
    chk("rst_sclk", 32'(d_sclk), 32'd0);
    chk("rst_mosi", 32'(d_mosi), 32'd0);
    chk("rst_ldac_n", 32'(d_ldac_n), 32'd1);
    chk("rst_busy", 32'(d_busy), 32'd0);
    chk("rst_pair_done", 32'(d_pd), 32'd0);
    chk("rst_fast_cs_n", 32'(f_cs_n), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush();

    // Directed pair
    one_pair(12'hABC, 12'h123, 1'b1, 1'b1, 1);
    check_pair("dir", 12'hABC, 12'h123, 1'b1, 1'b1, 2, 2, 2);

    // Channel 2 shut down
    ra = 12'($urandom);
    one_pair(ra, 12'hFFF, 1'b1, 1'b0, 1);
    check_pair("shdn2", ra, 12'hFFF, 1'b1, 1'b0, 2, 2, 2);

    // Random pairs, inputs scrambled every cycle after the snapshot
    for (int i = 0; i < 3; i++) begin
      ra = 12'($urandom); rb = 12'($urandom);
      rea = 1'($urandom_range(0, 1)); reb = 1'($urandom_range(0, 1));
      one_pair(ra, rb, rea, reb, 1);
      check_pair("rand", ra, rb, rea, reb, 2, 2, 2);
    end

    // en dropped in the middle of frame A
    ra = 12'($urandom); rb = 12'($urandom);
    one_pair(ra, rb, 1'b1, 1'b1, 40);
    check_pair("endrop", ra, rb, 1'b1, 1'b1, 2, 2, 2);
    repeat (30) @(posedge clk);
    #1;
    chk("endrop_stays_idle", 32'(d_busy), 32'd0);
    chk("endrop_no_new_frame", 32'(fr_q.size()), 32'd0);

    // Back-to-back pairs with en held
    b2b("b2b", 12'h5A5, 12'h0F0, 135);

    // Reset mid frame B
    flush();
    @(negedge clk);
    s1 = 12'h321; s2 = 12'h654; ch1_en = 1'b1; ch2_en = 1'b1;
    en_d = 1'b1;
    @(posedge clk);
    #1 en_d = 1'b0;
    n = 0;
    while (!(fr_q.size() == 1 && nbits == 7) && n < 500) begin @(posedge clk); #1; n++; end
    chk("rstB_reached", 32'(n < 500), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstB_cs_n", 32'(d_cs_n), 32'd1);
    chk("rstB_sclk", 32'(d_sclk), 32'd0);
    chk("rstB_mosi", 32'(d_mosi), 32'd0);
    chk("rstB_ldac_n", 32'(d_ldac_n), 32'd1);
    chk("rstB_busy", 32'(d_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("rstB_no_ldac", 32'(ld_q.size()), 32'd0);
    chk("rstB_no_pair_done", 32'(pd_cnt), 32'd0);
    flush();
    ra = 12'($urandom); rb = 12'($urandom);
    one_pair(ra, rb, 1'b1, 1'b1, 1);
    check_pair("after_rst", ra, rb, 1'b1, 1'b1, 2, 2, 2);

    // Fastest timing instance
    sel = 1;
    repeat (2) @(posedge clk);
    #1;
    flush();
    for (int i = 0; i < 2; i++) begin
      ra = 12'($urandom); rb = 12'($urandom);
      rea = 1'($urandom_range(0, 1)); reb = 1'($urandom_range(0, 1));
      one_pair(ra, rb, rea, reb, 1);
      check_pair("fast", ra, rb, rea, reb, 1, 1, 1);
    end
    b2b("fast_b2b", 12'h800, 12'h7FF, 68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
